// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags taken
// straight from the pointers; the name is historical, there is one clock domain.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  fifo_full,
    output logic                  fifo_empty
);

    // Handshake: a write is accepted on a rising edge when wren=1 and
    // fifo_full=0, a read when rden=1 and fifo_empty=0. Both qualifiers use the
    // flags as they stand before the edge; a refused request is dropped with no
    // side effect, and d_out only changes on an accepted read.

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [DATA_WIDTH-1:0] r_dout;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_wrap_diff;
    logic                  w_low_eq;

    assign w_wrap_diff = r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH];
    assign w_low_eq    = r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0];

    assign fifo_empty  = !w_wrap_diff && w_low_eq;
    assign fifo_full   = w_wrap_diff && w_low_eq;

    assign w_wr_en     = wren && !fifo_full;
    assign w_rd_en     = rden && !fifo_empty;

    assign d_out       = r_dout;

    // Storage is deliberately left out of reset; only pointers and d_out clear.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
        end else if (w_wr_en) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr <= '0;
            r_dout <= '0;
        end else if (w_rd_en) begin
            r_rptr <= r_rptr + 1'b1;
            r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, fill/drain, wrap-around, concurrent
// read/write and asynchronous mid-operation reset, checked against a queue.
module tb_async_fifo;

    logic       clk;
    logic       rst;
    logic       wren;
    logic       rden;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       fifo_full;
    logic       fifo_empty;

    logic [7:0] exp_q[$];
    logic [7:0] exp_dout;
    int         total;
    int         bad;

    async_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (16),
        .ADDR_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wren      (wren),
        .rden      (rden),
        .d_in      (d_in),
        .d_out     (d_out),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle from the falling edge, then sample 1ns after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        wren = w;
        rden = r;
        d_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        d_in = 8'h00;
        #1;
        total++;
        if (d_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_dout: got %h want 00", d_out);
        end
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got empty=%b full=%b want empty=1 full=0", fifo_empty, fifo_full);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || d_out !== 8'h00) begin
            bad++;
            $display("FAIL idle_after_reset: got empty=%b full=%b dout=%h want 1 0 00", fifo_empty, fifo_full, d_out);
        end
        exp_dout = 8'h00;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i + 1));
            exp_q.push_back(8'(i + 1));
            total++;
            if (fifo_empty !== 1'b0 || fifo_full !== (i == 15)) begin
                bad++;
                $display("FAIL fill_flags[%0d]: got empty=%b full=%b want empty=0 full=%b", i, fifo_empty, fifo_full, (i == 15));
            end
        end
        cycle(1'b1, 1'b0, 8'hAA);
        total++;
        if (fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL fill_overflow_full: got full=%b want 1", fifo_full);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout) begin
                bad++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, d_out, exp_dout);
            end
            total++;
            if (fifo_full !== 1'b0 || fifo_empty !== (i >= 15)) begin
                bad++;
                $display("FAIL drain_flags[%0d]: got empty=%b full=%b want empty=%b full=0", i, fifo_empty, fifo_full, (i >= 15));
            end
        end
        total++;
        if (d_out !== 8'h10) begin
            bad++;
            $display("FAIL drain_hold: got %h want 10", d_out);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h50 + i));
            exp_q.push_back(8'(8'h50 + i));
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout) begin
                bad++;
                $display("FAIL wrap_pre_data[%0d]: got %h want %h", i, d_out, exp_dout);
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
            total++;
            if (fifo_full !== (i == 15) || fifo_empty !== 1'b0) begin
                bad++;
                $display("FAIL wrap_fill_flags[%0d]: got full=%b empty=%b want full=%b empty=0", i, fifo_full, fifo_empty, (i == 15));
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout) begin
                bad++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, d_out, exp_dout);
            end
        end
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL wrap_empty: got empty=%b want 1", fifo_empty);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h60 + i));
            exp_q.push_back(8'(8'h60 + i));
        end
        for (int i = 0; i < 50; i++) begin
            v = 8'($urandom_range(0, 255));
            cycle(1'b1, 1'b1, v);
            exp_q.push_back(v);
            exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout) begin
                bad++;
                $display("FAIL simul_data[%0d]: got %h want %h", i, d_out, exp_dout);
            end
            total++;
            if (fifo_full !== 1'b0 || fifo_empty !== 1'b0) begin
                bad++;
                $display("FAIL simul_flags[%0d]: got full=%b empty=%b want 0 0", i, fifo_full, fifo_empty);
            end
        end
        // Occupancy must still be four: exactly four reads drain it.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout || fifo_empty !== (i == 3)) begin
                bad++;
                $display("FAIL simul_drain[%0d]: got dout=%h empty=%b want %h %b", i, d_out, fifo_empty, exp_dout, (i == 3));
            end
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_simul_empty_full();
        // Empty: concurrent request only writes, no read-through.
        cycle(1'b1, 1'b1, 8'h77);
        total++;
        if (d_out !== exp_dout || fifo_empty !== 1'b0) begin
            bad++;
            $display("FAIL simul_empty: got dout=%h empty=%b want %h 0", d_out, fifo_empty, exp_dout);
        end
        exp_q.push_back(8'h77);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        // Full: concurrent request only reads, write of 0xEE is dropped.
        cycle(1'b1, 1'b1, 8'hEE);
        exp_dout = exp_q.pop_front();
        total++;
        if (d_out !== exp_dout || fifo_full !== 1'b0) begin
            bad++;
            $display("FAIL simul_full: got dout=%h full=%b want %h 0", d_out, fifo_full, exp_dout);
        end
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            exp_dout = exp_q.pop_front();
            total++;
            if (d_out !== exp_dout) begin
                bad++;
                $display("FAIL simul_full_drain[%0d]: got %h want %h", i, d_out, exp_dout);
            end
        end
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL simul_full_dropped: got empty=%b want 1", fifo_empty);
        end
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h90 + i));
        end
        cycle(1'b0, 1'b1, 8'h00);
        total++;
        if (d_out !== 8'h90) begin
            bad++;
            $display("FAIL mid_pre_read: got %h want 90", d_out);
        end
        @(negedge clk);
        rden = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || d_out !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset_async: got empty=%b full=%b dout=%h want 1 0 00", fifo_empty, fifo_full, d_out);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 1'b1, 8'h00);
        total++;
        if (d_out !== 8'h00 || fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL mid_read_empty: got dout=%h empty=%b want 00 1", d_out, fifo_empty);
        end
        exp_q.delete();
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_simul_empty_full();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
